balance_display_scheduler: RTL and testbench
============================================

Name: balance_display_scheduler

Overview:
Sequences the single shared seven-segment display path between the five account balances (dollars, BTC, ETH, XRP, LTC). Supports manual stepping from the debounced up-button, timed auto-rotation, and a temporary override that jumps to any balance that has just changed. The block sits between the account balance registers and one seven_seg_decoder instance, and replaces per-account decoders plus the mux.

Parameters:
DWELL_TICKS, 3, ticks each account stays on screen in auto mode (legal 1..255)
HOLD_TICKS, 5, ticks a changed balance is held on screen in override (legal 1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle pulse from the seconds divider, synchronous to clk
adv  in  1  single-cycle debounced advance request (BTNU), synchronous to clk
auto_en  in  1  level; 1 = auto-rotate mode
bal_dollars  in  16  dollar balance
bal_btc  in  16  BTC balance
bal_eth  in  16  ETH balance
bal_xrp  in  16  XRP balance
bal_ltc  in  16  LTC balance
sel  out  3  account on display: 0 = dollars, 1 = btc, 2 = eth, 3 = xrp, 4 = ltc
disp_value  out  16  registered balance of account sel, feeds the decoder
load  out  1  one-cycle pulse in the cycle disp_value first shows a new sel
highlight  out  1  1 while in OVERRIDE (drives decoder blink)

Behaviour:
- Reset, asynchronous on rst_n low: state MANUAL; sel = 0; disp_value = 0; load = 0; highlight = 0; dwell_cnt = 0; hold_cnt = 0; saved_sel = 0; shadow registers = 0; primed = 0.
- Every cycle, disp_value <= balance[sel_next]. Output latency is 1 cycle from an input balance change. load = 1 exactly when sel_next != sel.
- Shadow registers capture all five balances every cycle. change[k] = primed && (bal_k != shadow_k). primed is set in the first cycle after reset, so no false change is detected after reset.
- advance(x): if x == 4 then 0, else x + 1. sel never leaves 0..4; an illegal state or sel value recovers to MANUAL with sel = 0.
- MANUAL state:
  - adv: sel = advance(sel).
  - auto_en = 1: go to AUTO with dwell_cnt = 0.
- AUTO state:
  - On tick: if dwell_cnt == DWELL_TICKS-1, then sel = advance(sel) and dwell_cnt = 0; otherwise dwell_cnt increments.
  - adv: sel = advance(sel) and dwell_cnt = 0. If adv and tick arrive in the same cycle, advance once and clear dwell_cnt.
  - auto_en = 0: go to MANUAL; sel is kept.
- Entering OVERRIDE:
  - Any change[k] seen in MANUAL or AUTO: saved_sel = sel; sel = lowest k with change; hold_cnt = 0; highlight = 1.
  - change takes priority over adv and tick in the same cycle.
- OVERRIDE state:
  - A new change[k] retargets sel = lowest k and restarts hold_cnt = 0. saved_sel is not modified.
  - On tick: hold_cnt increments. When hold_cnt == HOLD_TICKS-1 and tick arrives, exit.
  - adv: exit immediately (no advance).
  - On exit: sel = saved_sel; highlight = 0; dwell_cnt = 0; next state is AUTO if auto_en = 1, else MANUAL.
  - auto_en changes inside OVERRIDE take effect only at exit.
- Reset mid-override: all registers return to reset values; the saved selection is lost.

Test Plan:
- Release reset with nonzero balances (btc = 16'h0042): sel = 0, disp_value = dollars after 1 cycle, highlight stays 0.
- Manual mode, 6 adv pulses: sel goes 1, 2, 3, 4, 0, 1; load pulses 6 times; disp_value tracks the selected balance.
- auto_en = 1, DWELL_TICKS = 3, 7 ticks: sel advances after ticks 3 and 6 only. adv and tick in the same cycle: a single advance and dwell_cnt cleared.
- sel = 3, bal_eth changes from 0x0010 to 0x0020: next cycle sel = 2, highlight = 1, disp_value = 0x0020. After 5 ticks: sel = 3, highlight = 0.
- In OVERRIDE on eth, bal_btc changes at hold tick 2: sel = 1, hold restarts, and the final return is to the original sel = 3. adv mid-override returns to 3 immediately.
- Assert rst_n low during OVERRIDE: outputs return to reset values asynchronously (sel = 0, highlight = 0, disp_value = 0).

Source files
------------

// File: rtl/balance_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : balance_display_scheduler
// Purpose  : Chooses which of five balances feeds the shared 7-seg decoder:
//            manual stepping, timed auto-rotation, and change override.
// Revision : 1.0 - initial release
// ============================================================================
module balance_display_scheduler #(
   parameter int DWELL_TICKS = 3,
   parameter int HOLD_TICKS  = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        adv,
   input  logic        auto_en,
   input  logic [15:0] bal_dollars,
   input  logic [15:0] bal_btc,
   input  logic [15:0] bal_eth,
   input  logic [15:0] bal_xrp,
   input  logic [15:0] bal_ltc,
   output logic [2:0]  sel,
   output logic [15:0] disp_value,
   output logic        load,
   output logic        highlight
);

   typedef enum logic [1:0] {
      MANUAL   = 2'd0,
      AUTO     = 2'd1,
      OVERRIDE = 2'd2
   } state_t;

   localparam logic [7:0] c_dwell_last = 8'(DWELL_TICKS - 1);
   localparam logic [7:0] c_hold_last  = 8'(HOLD_TICKS - 1);

   state_t      r_state, w_state_n;
   logic [2:0]  r_sel, w_sel_n;
   logic [2:0]  r_saved_sel, w_saved_n;
   logic [7:0]  r_dwell, w_dwell_n;
   logic [7:0]  r_hold, w_hold_n;
   logic        r_highlight, w_highlight_n;
   logic        r_load;
   logic [15:0] r_disp, w_disp_n;
   logic        r_primed;
   logic [15:0] r_shadow [5];
   logic [15:0] w_bal [5];
   logic [4:0]  w_change;
   logic [2:0]  w_low;

   function automatic logic [2:0] advance(input logic [2:0] x);
      return (x == 3'd4) ? 3'd0 : x + 3'd1;
   endfunction

   assign w_bal[0] = bal_dollars;
   assign w_bal[1] = bal_btc;
   assign w_bal[2] = bal_eth;
   assign w_bal[3] = bal_xrp;
   assign w_bal[4] = bal_ltc;

   generate
      for (genvar k = 0; k < 5; k++) begin : g_change
         assign w_change[k] = r_primed && (w_bal[k] != r_shadow[k]);
      end
   endgenerate

   always_comb begin
      w_low = 3'd0;
      if      (w_change[0]) w_low = 3'd0;
      else if (w_change[1]) w_low = 3'd1;
      else if (w_change[2]) w_low = 3'd2;
      else if (w_change[3]) w_low = 3'd3;
      else if (w_change[4]) w_low = 3'd4;
   end

   always_comb begin
      w_state_n     = r_state;
      w_sel_n       = r_sel;
      w_saved_n     = r_saved_sel;
      w_dwell_n     = r_dwell;
      w_hold_n      = r_hold;
      w_highlight_n = r_highlight;
      if (r_sel > 3'd4) begin
         w_state_n     = MANUAL;
         w_sel_n       = 3'd0;
         w_highlight_n = 1'b0;
      end else begin
         case (r_state)
            MANUAL, AUTO: begin
               if (|w_change) begin
                  w_state_n     = OVERRIDE;
                  w_saved_n     = r_sel;
                  w_sel_n       = w_low;
                  w_hold_n      = 8'd0;
                  w_highlight_n = 1'b1;
               end else if (r_state == MANUAL) begin
                  if (adv) w_sel_n = advance(r_sel);
                  if (auto_en) begin
                     w_state_n = AUTO;
                     w_dwell_n = 8'd0;
                  end
               end else begin
                  // adv wins over a coincident tick: one step, dwell restarts
                  if (adv) begin
                     w_sel_n   = advance(r_sel);
                     w_dwell_n = 8'd0;
                  end else if (tick) begin
                     if (r_dwell == c_dwell_last) begin
                        w_sel_n   = advance(r_sel);
                        w_dwell_n = 8'd0;
                     end else begin
                        w_dwell_n = r_dwell + 8'd1;
                     end
                  end
                  if (!auto_en) w_state_n = MANUAL;
               end
            end
            OVERRIDE: begin
               if (|w_change) begin
                  w_sel_n  = w_low;
                  w_hold_n = 8'd0;
               end else if (adv || (tick && r_hold == c_hold_last)) begin
                  w_sel_n       = r_saved_sel;
                  w_highlight_n = 1'b0;
                  w_dwell_n     = 8'd0;
                  w_state_n     = auto_en ? AUTO : MANUAL;
               end else if (tick) begin
                  w_hold_n = r_hold + 8'd1;
               end
            end
            default: begin
               w_state_n     = MANUAL;
               w_sel_n       = 3'd0;
               w_highlight_n = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_disp_n = 16'd0;
      case (w_sel_n)
         3'd0:    w_disp_n = bal_dollars;
         3'd1:    w_disp_n = bal_btc;
         3'd2:    w_disp_n = bal_eth;
         3'd3:    w_disp_n = bal_xrp;
         3'd4:    w_disp_n = bal_ltc;
         default: w_disp_n = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= MANUAL;
         r_sel       <= 3'd0;
         r_saved_sel <= 3'd0;
         r_dwell     <= 8'd0;
         r_hold      <= 8'd0;
         r_highlight <= 1'b0;
         r_load      <= 1'b0;
         r_disp      <= 16'd0;
         r_primed    <= 1'b0;
         for (int k = 0; k < 5; k++) r_shadow[k] <= 16'd0;
      end else begin
         r_state     <= w_state_n;
         r_sel       <= w_sel_n;
         r_saved_sel <= w_saved_n;
         r_dwell     <= w_dwell_n;
         r_hold      <= w_hold_n;
         r_highlight <= w_highlight_n;
         r_load      <= (w_sel_n != r_sel);
         r_disp      <= w_disp_n;
         r_primed    <= 1'b1;
         for (int k = 0; k < 5; k++) r_shadow[k] <= w_bal[k];
      end
   end

   assign sel        = r_sel;
   assign disp_value = r_disp;
   assign load       = r_load;
   assign highlight  = r_highlight;

endmodule
`default_nettype wire

// File: tb/tb_balance_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_balance_display_scheduler
// Purpose  : Directed self-checking bench for balance_display_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_balance_display_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick, adv, auto_en;
   logic [15:0] bal_dollars, bal_btc, bal_eth, bal_xrp, bal_ltc;
   logic [2:0]  sel;
   logic [15:0] disp_value;
   logic        load, highlight;

   int n_tests = 0;
   int n_fail  = 0;
   int load_cnt = 0;

   balance_display_scheduler #(.DWELL_TICKS(3), .HOLD_TICKS(5)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .adv(adv), .auto_en(auto_en),
      .bal_dollars(bal_dollars), .bal_btc(bal_btc), .bal_eth(bal_eth),
      .bal_xrp(bal_xrp), .bal_ltc(bal_ltc),
      .sel(sel), .disp_value(disp_value), .load(load), .highlight(highlight)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (load === 1'b1) load_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1; step(); tick = 1'b0;
   endtask

   task automatic pulse_adv();
      adv = 1'b1; step(); adv = 1'b0;
   endtask

   function automatic logic [15:0] bal_of(input logic [2:0] s);
      case (s)
         3'd0: return bal_dollars;
         3'd1: return bal_btc;
         3'd2: return bal_eth;
         3'd3: return bal_xrp;
         default: return bal_ltc;
      endcase
   endfunction

   initial begin
      logic [2:0] man_seq [6];
      int base;
      man_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

      rst_n = 1'b0; tick = 1'b0; adv = 1'b0; auto_en = 1'b0;
      bal_dollars = 16'h1234; bal_btc = 16'h0042; bal_eth = 16'h0010;
      bal_xrp = 16'h0303; bal_ltc = 16'h0404;
      #1;
      check("rst_sel", sel, 0);
      check("rst_disp", disp_value, 0);
      check("rst_load", load, 0);
      check("rst_hl", highlight, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_sel", sel, 0);
      check("post_rst_disp", disp_value, 16'h1234);
      check("post_rst_hl", highlight, 0);
      step();
      check("post_rst_hl2", highlight, 0);
      check("post_rst_load", load, 0);

      // manual stepping
      base = load_cnt;
      for (int i = 0; i < 6; i++) begin
         pulse_adv();
         check("man_sel", sel, man_seq[i]);
         check("man_disp", disp_value, bal_of(man_seq[i]));
         check("man_load", load, 1);
      end
      step();
      check("man_load_idle", load, 0);
      check("man_load_cnt", load_cnt - base, 6);

      // auto rotation from sel=1
      auto_en = 1'b1;
      step();
      check("auto_enter_sel", sel, 1);
      for (int i = 1; i <= 7; i++) begin
         pulse_tick();
         check("auto_tick_sel", sel, (i < 3) ? 1 : (i < 6) ? 2 : 3);
      end
      adv = 1'b1; tick = 1'b1; step(); adv = 1'b0; tick = 1'b0;
      check("auto_adv_tick_sel", sel, 4);
      pulse_tick(); pulse_tick();
      check("auto_dwell_clr_sel", sel, 4);
      pulse_tick();
      check("auto_wrap_sel", sel, 0);

      // back to manual, move to xrp
      auto_en = 1'b0;
      step();
      pulse_adv(); pulse_adv(); pulse_adv();
      check("man_to_xrp", sel, 3);

      // override on eth change
      bal_eth = 16'h0020;
      step();
      check("ovr_sel", sel, 2);
      check("ovr_hl", highlight, 1);
      check("ovr_disp", disp_value, 16'h0020);
      check("ovr_load", load, 1);
      for (int i = 1; i <= 4; i++) begin
         pulse_tick();
         check("ovr_hold_sel", sel, 2);
      end
      pulse_tick();
      check("ovr_exit_sel", sel, 3);
      check("ovr_exit_hl", highlight, 0);
      check("ovr_exit_disp", disp_value, 16'h0303);

      // retarget inside override
      bal_eth = 16'h0030;
      step();
      check("rt_sel_eth", sel, 2);
      pulse_tick(); pulse_tick();
      bal_btc = 16'h0055;
      step();
      check("rt_sel_btc", sel, 1);
      check("rt_disp_btc", disp_value, 16'h0055);
      check("rt_hl", highlight, 1);
      for (int i = 1; i <= 4; i++) begin
         pulse_tick();
         check("rt_hold_sel", sel, 1);
      end
      pulse_tick();
      check("rt_exit_sel", sel, 3);
      check("rt_exit_hl", highlight, 0);

      // adv exits immediately without advancing
      bal_ltc = 16'h0077;
      step();
      check("adv_ovr_sel", sel, 4);
      check("adv_ovr_hl", highlight, 1);
      pulse_adv();
      check("adv_exit_sel", sel, 3);
      check("adv_exit_hl", highlight, 0);

      // reset mid-override
      bal_eth = 16'h0040;
      step();
      check("rst_ovr_sel_pre", sel, 2);
      #2 rst_n = 1'b0;
      #1;
      check("rst_ovr_sel", sel, 0);
      check("rst_ovr_hl", highlight, 0);
      check("rst_ovr_disp", disp_value, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_rel_sel", sel, 0);
      check("rst_rel_hl", highlight, 0);
      check("rst_rel_disp", disp_value, 16'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
